// File: rtl/uart_bus_bridge.sv
// UART debug bridge: framed serial commands become single read/write cycles on
// the peripheral register bus; the write ack or the read data goes back over uart_tx.
module uart_bus_bridge #(
  parameter int unsigned BAUD_DIV       = 86,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        we,
  output logic        re,
  output logic        busy
);

  localparam int unsigned BCW = $clog2(BAUD_DIV);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {CMD_IDLE, CMD_ADDR, CMD_WDATA, CMD_BUS, CMD_RESP} cmd_state_e;

  // ---------------------------------------------------------------- receiver
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e      rx_state_q, rx_state_d;
  logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_valid_q, rx_valid_d;
  logic           rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------------------------------------------------- command engine
  cmd_state_e     state_q, state_d;
  logic           op_write_q, op_write_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    address_q, address_d;
  logic [31:0]    write_data_q, write_data_d;
  logic [31:0]    resp_q, resp_d;
  logic [1:0]     resp_left_q, resp_left_d;
  logic [9:0]     tx_frame_q, tx_frame_d;
  logic [BCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]     tx_bit_q, tx_bit_d;
  logic [TCW-1:0] tmo_q, tmo_d;

  always_comb begin
    state_d      = state_q;
    op_write_d   = op_write_q;
    byte_cnt_d   = byte_cnt_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    resp_d       = resp_q;
    resp_left_d  = resp_left_q;
    tx_frame_d   = tx_frame_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tmo_d        = '0;
    unique case (state_q)
      CMD_IDLE: begin
        if (rx_valid_q) begin
          byte_cnt_d = '0;
          if (rx_shift_q == OP_WRITE || rx_shift_q == OP_READ) begin
            op_write_d = (rx_shift_q == OP_WRITE);
            state_d    = CMD_ADDR;
          end else begin
            tx_frame_d  = {1'b1, RSP_BAD, 1'b0};
            tx_cnt_d    = '0;
            tx_bit_d    = '0;
            resp_left_d = '0;
            state_d     = CMD_RESP;
          end
        end
      end
      CMD_ADDR: begin
        if (rx_ferr_q) begin
          state_d = CMD_IDLE;
        end else if (rx_valid_q) begin
          address_d  = {rx_shift_q, address_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = op_write_q ? CMD_WDATA : CMD_BUS;
        end else if (tmo_q == TMO_LAST) begin
          state_d = CMD_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CMD_WDATA: begin
        if (rx_ferr_q) begin
          state_d = CMD_IDLE;
        end else if (rx_valid_q) begin
          write_data_d = {rx_shift_q, write_data_q[31:8]};
          byte_cnt_d   = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = CMD_BUS;
        end else if (tmo_q == TMO_LAST) begin
          state_d = CMD_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CMD_BUS: begin
        // The first start bit is loaded here so it leaves on the very next cycle.
        tx_cnt_d = '0;
        tx_bit_d = '0;
        state_d  = CMD_RESP;
        if (op_write_q) begin
          tx_frame_d  = {1'b1, RSP_ACK, 1'b0};
          resp_left_d = '0;
        end else begin
          tx_frame_d  = {1'b1, read_data[7:0], 1'b0};
          resp_d      = {8'h00, read_data[31:8]};
          resp_left_d = 2'd3;
        end
      end
      CMD_RESP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (resp_left_q != 2'd0) begin
              tx_frame_d  = {1'b1, resp_q[7:0], 1'b0};
              resp_d      = {8'h00, resp_q[31:8]};
              resp_left_d = resp_left_q - 2'd1;
            end else begin
              tx_frame_d = '1;
              state_d    = CMD_IDLE;
            end
          end else begin
            tx_frame_d = {1'b1, tx_frame_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CMD_IDLE;
      op_write_q   <= 1'b0;
      byte_cnt_q   <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      resp_q       <= '0;
      resp_left_q  <= '0;
      tx_frame_q   <= '1;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_write_q   <= op_write_d;
      byte_cnt_q   <= byte_cnt_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      resp_q       <= resp_d;
      resp_left_q  <= resp_left_d;
      tx_frame_q   <= tx_frame_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tmo_q        <= tmo_d;
    end
  end

  assign uart_tx    = tx_frame_q[0];
  assign address    = address_q;
  assign write_data = write_data_q;
  assign we         = (state_q == CMD_BUS) && op_write_q;
  assign re         = (state_q == CMD_BUS) && !op_write_q;
  assign busy       = (state_q != CMD_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus cycles and
// response bytes; independent monitors pop and compare as the DUT produces them.
module tb_uart_bus_bridge;

  localparam int BD = 8;

  logic        clk;
  logic        rst_n;
  logic        uart_rx;
  logic        uart_tx;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;
  logic        busy;

  uart_bus_bridge #(
    .BAUD_DIV      (BD),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .we        (we),
    .re        (re),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign read_data = (address == 32'h0000_0008) ? 32'h0000_003C : (32'hA5A5_0000 | address);

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] tx_q[$];
  int         tx_falls[$];
  int         checks = 0;
  int         passes = 0;
  int         strobe_cyc = -100;
  int         rst_epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // bus monitor
  initial begin : bus_mon
    bit   prev;
    bus_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (we || re) begin
          check("strobe_onehot", 32'(we ^ re), 32'd1);
          check("strobe_one_cycle", 32'(prev), 32'd0);
          check("strobe_expected", 32'(bus_q.size() > 0), 32'd1);
          if (bus_q.size() > 0) begin
            e = bus_q.pop_front();
            check("bus_kind_we", 32'(we), 32'(e.wr));
            check("bus_addr", address, e.addr);
            if (e.wr) check("bus_wdata", write_data, e.wdata);
          end
          strobe_cyc = cyc;
        end
        prev = we || re;
      end
    end
  end

  // serial response monitor
  initial begin : tx_mon
    logic [7:0] b;
    logic       stopb;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        ep = rst_epoch;
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BD) @(negedge clk);
        stopb = uart_tx;
        if (ep == rst_epoch) begin
          check("tx_stop_bit", 32'(stopb), 32'd1);
          check("tx_expected", 32'(tx_q.size() > 0), 32'd1);
          if (tx_q.size() > 0) check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin : tx_fall_rec
    logic p;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (p && !uart_tx) tx_falls.push_back(cyc);
      p = uart_tx;
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stopb = 1'b1);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stopb;
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic finish_resp(input string name, input int exp_len, input bit chk_strobe);
    bit ok;
    int t_done;
    ok = 1'b0;
    t_done = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        t_done = cyc;
      end
    end
    check({name, "_busy_falls"}, 32'(ok), 32'd1);
    check({name, "_tx_started"}, 32'(tx_falls.size() > 0), 32'd1);
    if (ok && tx_falls.size() > 0) begin
      check({name, "_resp_len"}, t_done - tx_falls[0], exp_len);
      if (chk_strobe) check({name, "_strobe_to_tx"}, tx_falls[0] - strobe_cyc, 32'd1);
    end
  endtask

  initial begin : stim
    bit ok;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_address", address, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_re", 32'(re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // write 0xDEADBEEF to 0x10
    tx_falls.delete();
    bus_q.push_back('{wr: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF});
    tx_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h0000_0010);
    send_word(32'hDEADBEEF);
    check("wr_busy_during_resp", 32'(busy), 32'd1);
    finish_resp("wr", 80, 1'b1);
    repeat (10) @(negedge clk);

    // read 0x08 -> 3C 00 00 00 back to back
    tx_falls.delete();
    bus_q.push_back('{wr: 1'b0, addr: 32'h8, wdata: 32'h0});
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    send_byte(8'h52);
    send_word(32'h0000_0008);
    finish_resp("rd", 320, 1'b1);
    repeat (10) @(negedge clk);

    // unknown opcode
    tx_falls.delete();
    tx_q.push_back(8'h3F);
    send_byte(8'hA5);
    finish_resp("badop", 80, 1'b0);
    repeat (10) @(negedge clk);

    // timeout mid-address, then a normal read
    send_byte(8'h52);
    send_byte(8'h08);
    check("tmo_busy_in_cmd", 32'(busy), 32'd1);
    repeat (250) @(negedge clk);
    check("tmo_busy_after", 32'(busy), 32'd0);
    tx_falls.delete();
    bus_q.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'h0});
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'hA5);
    send_byte(8'h52);
    send_word(32'h0000_0100);
    finish_resp("rd2", 320, 1'b1);
    repeat (10) @(negedge clk);

    // framing error mid-command
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy", 32'(busy), 32'd0);

    // short low glitch on an idle line
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);

    // reset during the read response
    tx_falls.delete();
    bus_q.push_back('{wr: 1'b0, addr: 32'h8, wdata: 32'h0});
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    send_byte(8'h52);
    send_word(32'h0000_0008);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (tx_falls.size() > 0) ok = 1'b1;
      else @(negedge clk);
    end
    check("rstresp_tx_started", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    rst_epoch++;
    tx_q.delete();
    #1;
    check("rstresp_uart_tx", 32'(uart_tx), 32'd1);
    check("rstresp_busy", 32'(busy), 32'd0);
    check("rstresp_we", 32'(we), 32'd0);
    check("rstresp_re", 32'(re), 32'd0);
    check("rstresp_address", address, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    tx_falls.delete();
    bus_q.push_back('{wr: 1'b1, addr: 32'h20, wdata: 32'h12345678});
    tx_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h0000_0020);
    send_word(32'h1234_5678);
    finish_resp("wr2", 80, 1'b1);
    repeat (10) @(negedge clk);

    check("bus_q_drained", bus_q.size(), 32'd0);
    check("tx_q_drained", tx_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
